// File: rtl/filter_mode_scheduler.sv
// Frame-synchronous mode/timing controller for the VGA filter pipeline.
// Tracks VGA timing, resolves the filter mode from SW/KEY and commits it
// only on a VS falling edge so the kernel mux never changes mid-frame.
// Ports:
//   VGA_CLK, reset          pixel clock, async active-high reset
//   iVGA_HS/VS/BLANK_N      raw VGA timing (HS carried for alignment only)
//   SW, KEY                 direct mode select, active-low step buttons
//   mode, mode_pending      committed mode, request differs from commit
//   pix_x, pix_y, border    active pixel position and kernel border mask
//   frame_cnt               committed frames (wraps)
//   last_line_len, line_err line-length diagnostics
module filter_mode_scheduler #(
  parameter int WIDTH    = 800,
  parameter int HEIGHT   = 480,
  parameter int MAX_MODE = 11,
  parameter int BORDER   = 1,
  parameter int DEBOUNCE = 250000
) (
  input  logic       VGA_CLK,
  input  logic       reset,
  input  logic       iVGA_HS,
  input  logic       iVGA_VS,
  input  logic       iVGA_BLANK_N,
  input  logic [7:0] SW,
  input  logic [1:0] KEY,
  output logic [3:0] mode,
  output logic       mode_pending,
  output logic [9:0] pix_x,
  output logic [8:0] pix_y,
  output logic       border,
  output logic [7:0] frame_cnt,
  output logic [9:0] last_line_len,
  output logic       line_err
);

  localparam int DBW = $clog2(DEBOUNCE + 1);

  typedef enum logic [1:0] {
    SYNC_WAIT,
    VBLANK,
    LINE,
    HBLANK
  } state_t;

  state_t state, state_nxt;

  logic           vs_r, vs_d;
  logic           bn_r, bn_d;
  logic           hs_unused;
  logic [7:0]     sw_r;
  logic [1:0]     k_meta, k_sync, k_prev;

  logic           vs_fall, bn_rise, bn_fall;
  logic           line_end;
  logic [9:0]     len_c;
  logic [9:0]     x_nxt;
  logic [8:0]     y_nxt;
  logic           bord_c;

  logic [3:0]     step, step_nxt;
  logic [DBW-1:0] db;
  logic [1:0]     press;
  logic [3:0]     req_c, req_q;
  logic [3:0]     mode_nxt;

  // input registers; KEY gets a 2-FF synchroniser plus an edge stage
  always_ff @(posedge VGA_CLK or posedge reset) begin
    if (reset) begin
      vs_r      <= 1'b0;
      vs_d      <= 1'b0;
      bn_r      <= 1'b0;
      bn_d      <= 1'b0;
      hs_unused <= 1'b1;
      sw_r      <= '0;
      k_meta    <= 2'b11;
      k_sync    <= 2'b11;
      k_prev    <= 2'b11;
    end else begin
      vs_r      <= iVGA_VS;
      vs_d      <= vs_r;
      bn_r      <= iVGA_BLANK_N;
      bn_d      <= bn_r;
      hs_unused <= iVGA_HS;
      sw_r      <= SW;
      k_meta    <= KEY;
      k_sync    <= k_meta;
      k_prev    <= k_sync;
    end
  end

  assign vs_fall = vs_d & ~vs_r;
  assign bn_rise = bn_r & ~bn_d;
  assign bn_fall = bn_d & ~bn_r;

  // VS wins over a coincident BLANK_N edge
  always_comb begin
    state_nxt = state;
    unique case (state)
      SYNC_WAIT: if (vs_fall) state_nxt = VBLANK;
      VBLANK: begin
        if (vs_fall)      state_nxt = VBLANK;
        else if (bn_rise) state_nxt = LINE;
      end
      LINE: begin
        if (vs_fall)      state_nxt = VBLANK;
        else if (bn_fall) state_nxt = HBLANK;
      end
      HBLANK: begin
        if (vs_fall)      state_nxt = VBLANK;
        else if (bn_rise) state_nxt = LINE;
      end
    endcase
  end

  assign line_end = (state == LINE) & bn_fall & ~vs_fall;
  // pix_x holds the last pixel index, so the count is one more
  assign len_c = (pix_x == 10'h3FF) ? 10'h3FF : pix_x + 10'd1;

  always_comb begin
    x_nxt = pix_x;
    if (bn_rise)
      x_nxt = '0;
    else if (state == LINE && bn_r && pix_x != 10'h3FF)
      x_nxt = pix_x + 10'd1;
    y_nxt = pix_y;
    if (vs_fall)
      y_nxt = '0;
    else if (line_end && pix_y != 9'h1FF)
      y_nxt = pix_y + 9'd1;
  end

  // mask uses next coordinates so it aligns with pix_x/pix_y
  assign bord_c = bn_r & ((x_nxt <  10'(BORDER))
                        | (x_nxt >= 10'(WIDTH - BORDER))
                        | (y_nxt <  9'(BORDER))
                        | (y_nxt >= 9'(HEIGHT - BORDER)));

  assign press = k_prev & ~k_sync & {2{db == '0}};

  always_comb begin
    step_nxt = step;
    unique case (1'b1)
      (press == 2'b01):
        step_nxt = (step == 4'(MAX_MODE)) ? 4'd0 : step + 4'd1;
      (press == 2'b10):
        step_nxt = (step == 4'd0) ? 4'(MAX_MODE) : step - 4'd1;
      default: step_nxt = step;
    endcase
  end

  always_comb begin
    req_c = '0;
    if (sw_r == 8'd0)
      req_c = step;
    else if (sw_r <= 8'(MAX_MODE))
      req_c = sw_r[3:0];
  end

  assign mode_nxt = vs_fall ? req_q : mode;

  always_ff @(posedge VGA_CLK or posedge reset) begin
    if (reset) begin
      state         <= SYNC_WAIT;
      pix_x         <= '0;
      pix_y         <= '0;
      border        <= 1'b0;
      last_line_len <= '0;
      line_err      <= 1'b0;
      frame_cnt     <= '0;
      mode          <= '0;
      mode_pending  <= 1'b0;
      req_q         <= '0;
      step          <= '0;
      db            <= '0;
    end else begin
      state        <= state_nxt;
      pix_x        <= x_nxt;
      pix_y        <= y_nxt;
      border       <= bord_c;
      mode         <= mode_nxt;
      req_q        <= req_c;
      mode_pending <= (req_q != mode_nxt);
      step         <= step_nxt;
      if (line_end)
        last_line_len <= len_c;
      if (vs_fall)
        line_err <= 1'b0;
      else if (line_end && len_c != 10'(WIDTH))
        line_err <= 1'b1;
      if (vs_fall)
        frame_cnt <= frame_cnt + 8'd1;
      if (|press)
        db <= DBW'(DEBOUNCE);
      else if (db != '0)
        db <= db - DBW'(1);
    end
  end

endmodule

// File: tb/tb_filter_mode_scheduler.sv
// Directed bench for filter_mode_scheduler on a scaled 40x10 frame.
// Checks reset, commit timing, key stepping, border mask, line diagnostics.
module tb_filter_mode_scheduler;

  localparam int W  = 40;
  localparam int H  = 10;
  localparam int MM = 11;
  localparam int DB = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       hs, vs, bn;
  logic [7:0] sw;
  logic [1:0] key;
  logic [3:0] mode;
  logic       mode_pending;
  logic [9:0] pix_x;
  logic [8:0] pix_y;
  logic       border;
  logic [7:0] frame_cnt;
  logic [9:0] last_line_len;
  logic       line_err;

  int checks = 0;
  int errors = 0;

  logic c_chk = 1'b0, c_xy = 1'b0, c_b = 1'b0;
  int   c_x = 0, c_y = 0;
  logic d1_chk = 1'b0, d1_xy = 1'b0, d1_b = 1'b0;
  logic d2_chk = 1'b0, d2_xy = 1'b0, d2_b = 1'b0;
  int   d1_x = 0, d1_y = 0, d2_x = 0, d2_y = 0;

  always #5 clk = ~clk;

  filter_mode_scheduler #(
    .WIDTH(W), .HEIGHT(H), .MAX_MODE(MM),
    .BORDER(1), .DEBOUNCE(DB)
  ) dut (
    .VGA_CLK(clk),
    .reset(rst),
    .iVGA_HS(hs),
    .iVGA_VS(vs),
    .iVGA_BLANK_N(bn),
    .SW(sw),
    .KEY(key),
    .mode(mode),
    .mode_pending(mode_pending),
    .pix_x(pix_x),
    .pix_y(pix_y),
    .border(border),
    .frame_cnt(frame_cnt),
    .last_line_len(last_line_len),
    .line_err(line_err)
  );

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // stimulus coordinates reach the outputs two edges later
  always @(posedge clk) begin
    d1_chk <= c_chk; d1_xy <= c_xy; d1_b <= c_b;
    d1_x <= c_x; d1_y <= c_y;
    d2_chk <= d1_chk; d2_xy <= d1_xy; d2_b <= d1_b;
    d2_x <= d1_x; d2_y <= d1_y;
  end

  always @(negedge clk) begin
    if (d2_chk) begin
      chk("border", int'(border), int'(d2_b));
      if (d2_xy) begin
        chk("pix_x", int'(pix_x), d2_x);
        chk("pix_y", int'(pix_y), d2_y);
      end
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_mode"}, int'(mode), 0);
    chk({tag, "_pend"}, int'(mode_pending), 0);
    chk({tag, "_x"}, int'(pix_x), 0);
    chk({tag, "_y"}, int'(pix_y), 0);
    chk({tag, "_border"}, int'(border), 0);
    chk({tag, "_cnt"}, int'(frame_cnt), 0);
    chk({tag, "_len"}, int'(last_line_len), 0);
    chk({tag, "_err"}, int'(line_err), 0);
  endtask

  task automatic hook(input int act, input int y);
    case (act)
      1: begin
        if (y == 5) sw = 8'd9;
        if (y == 7) begin
          chk("mode_hold", int'(mode), 5);
          chk("pend_mid", int'(mode_pending), 1);
        end
      end
      2: if (y == 4) begin
        chk("len_short", int'(last_line_len), W - 1);
        chk("err_set", int'(line_err), 1);
      end
      3: if (y == 0) chk("err_clr", int'(line_err), 0);
      4: if (y == 5) begin
        rst = 1'b1;
        #1;
        chk_zero("rst_mid");
        cyc(2);
        rst = 1'b0;
        cyc(2);
      end
      default: ;
    endcase
  endtask

  task automatic frame(input int short_ln, input int act, input bit mon);
    int len;
    c_chk = 1'b0;
    c_xy  = 1'b0;
    vs = 1'b0; bn = 1'b0;
    cyc(3);
    vs = 1'b1;
    cyc(4);
    for (int y = 0; y < H; y++) begin
      hook(act, y);
      len = (y == short_ln) ? W - 1 : W;
      for (int x = 0; x < len; x++) begin
        bn    = 1'b1;
        c_chk = mon && (x <= 1 || x == len - 1);
        c_xy  = c_chk;
        c_x   = x;
        c_y   = y;
        c_b   = (x < 1) || (x >= W - 1) || (y < 1) || (y >= H - 1);
        cyc();
      end
      bn = 1'b0; hs = 1'b0;
      c_chk = mon; c_xy = 1'b0; c_b = 1'b0;
      cyc();
      c_chk = 1'b0;
      cyc(3);
      hs = 1'b1;
      cyc(2);
    end
    cyc(4);
  endtask

  task automatic press(input logic [1:0] k, input bit bounce);
    key = ~k;
    if (bounce) begin
      cyc(5);
      key = 2'b11;
      cyc(2);
      key = ~k;
      cyc(3);
    end else begin
      cyc(10);
    end
    key = 2'b11;
    cyc(20);
  endtask

  initial begin
    rst = 1'b1; vs = 1'b1; hs = 1'b1; bn = 1'b0;
    sw = 8'd5; key = 2'b11;
    cyc(3);
    chk_zero("rst");
    rst = 1'b0;
    cyc(3);

    frame(-1, 0, 1'b0);
    chk("f1_mode", int'(mode), 5);
    chk("f1_cnt", int'(frame_cnt), 1);
    chk("f1_len", int'(last_line_len), W);
    chk("f1_y", int'(pix_y), H);
    frame(-1, 0, 1'b0);
    frame(-1, 0, 1'b0);
    chk("f3_cnt", int'(frame_cnt), 3);
    chk("f3_err", int'(line_err), 0);
    chk("f3_len", int'(last_line_len), W);

    frame(-1, 1, 1'b0);
    chk("f4_mode", int'(mode), 5);
    chk("f4_pend", int'(mode_pending), 1);
    frame(-1, 0, 1'b1);
    chk("f5_mode", int'(mode), 9);
    chk("f5_pend", int'(mode_pending), 0);
    chk("f5_cnt", int'(frame_cnt), 5);

    frame(3, 2, 1'b0);
    chk("f6_err", int'(line_err), 1);
    chk("f6_len", int'(last_line_len), W);
    frame(-1, 3, 1'b0);
    chk("f7_cnt", int'(frame_cnt), 7);

    sw = 8'd0;
    cyc(4);
    press(2'b01, 1'b0);
    press(2'b01, 1'b1);
    press(2'b01, 1'b0);
    chk("k_pend", int'(mode_pending), 1);
    chk("k_hold", int'(mode), 9);
    frame(-1, 0, 1'b0);
    chk("k_up", int'(mode), 3);

    press(2'b10, 1'b0);
    press(2'b10, 1'b1);
    press(2'b10, 1'b0);
    press(2'b10, 1'b0);
    frame(-1, 0, 1'b0);
    chk("k_down", int'(mode), MM);
    press(2'b11, 1'b0);
    chk("k_both", int'(mode_pending), 0);

    sw = 8'd200;
    cyc(4);
    chk("sw_bad_pend", int'(mode_pending), 1);
    frame(-1, 0, 1'b0);
    chk("sw_bad", int'(mode), 0);
    chk("f10_cnt", int'(frame_cnt), 10);

    sw = 8'd7;
    cyc(4);
    frame(-1, 4, 1'b0);
    chk("sw_y", int'(pix_y), 0);
    chk("sw_x", int'(pix_x), 0);
    chk("sw_len", int'(last_line_len), 0);
    chk("sw_cnt", int'(frame_cnt), 0);
    chk("sw_mode", int'(mode), 0);
    frame(-1, 0, 1'b0);
    chk("post_mode", int'(mode), 7);
    chk("post_cnt", int'(frame_cnt), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
